// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-detection AHB master datapath.
// Holds the read-window sequencer state encoding and the window geometry.
package edge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    R0,
    R1,
    R2,
    DONE
  } rd_state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WIN_ROWS   = 3;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear and programmable rollover value.
// rollover_flag_o is decoded from the registered count.
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    count_enable_i,
  input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
  output logic                    rollover_flag_o
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_enable_i) begin
      // Wraps to 1, not 0: a running count never revisits the cleared value
      if (count_q == rollover_val_i) begin
        count_d = NUM_CNT_BITS'(1);
      end else begin
        count_d = count_q + NUM_CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign rollover_flag_o = (count_q == rollover_val_i);

endmodule

// File: rtl/read_window_addr_gen.sv
// Read-side address sequencer: walks the image in 3-row bands, issuing the three
// stacked word addresses of each column for a 3x3 Sobel window.
module read_window_addr_gen
  import edge_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DIM_W  = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  length,
  input  logic [DIM_W-1:0]  width,
  input  logic              beat_ack,
  input  logic              plus4_r,
  output logic              addr_update_enable_r,
  output logic [ADDR_W-1:0] HADDR_r,
  output logic              addr_valid,
  output logic              band_done,
  output logic              frame_done,
  output logic              busy
);

  rd_state_t         state_q, state_d;
  logic [DIM_W-1:0]  length_q, length_d;
  logic [DIM_W-1:0]  width_q, width_d;
  logic [ADDR_W-1:0] band_base_q, band_base_d;
  logic [ADDR_W-1:0] col_base_q, col_base_d;
  logic              upd_q, upd_d;
  logic              band_done_q, band_done_d;

  logic              cnt_clear, cnt_en, last_band;
  logic [ADDR_W-1:0] len_ext, len2_ext;

  assign len_ext  = ADDR_W'(length_q);
  assign len2_ext = ADDR_W'({length_q, 1'b0});

  // Counter holds (bands started); it equals width-2 exactly on the last band.
  flex_counter #(
    .NUM_CNT_BITS(DIM_W)
  ) u_band_cnt (
    .clk_i          (HCLK),
    .rst_ni         (HRESETn),
    .clear_i        (cnt_clear),
    .count_enable_i (cnt_en),
    .rollover_val_i (width_q - DIM_W'(2)),
    .rollover_flag_o(last_band)
  );

  always_comb begin
    state_d     = state_q;
    length_d    = length_q;
    width_d     = width_q;
    band_base_d = band_base_q;
    col_base_d  = col_base_q;
    upd_d       = 1'b0;
    band_done_d = 1'b0;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          length_d    = length;
          width_d     = width;
          band_base_d = base_addr;
          col_base_d  = base_addr;
          cnt_en      = 1'b1;
          if (width < DIM_W'(WIN_ROWS) || length < DIM_W'(WORD_BYTES)) begin
            state_d = DONE;
          end else begin
            state_d = R0;
          end
        end
      end
      R0: if (beat_ack) state_d = R1;
      R1: if (beat_ack) state_d = R2;
      R2: begin
        if (beat_ack) begin
          upd_d = 1'b1;
          if (!plus4_r) begin
            col_base_d = col_base_q + ADDR_W'(WORD_BYTES);
            state_d    = R0;
          end else if (!last_band) begin
            cnt_en      = 1'b1;
            band_base_d = band_base_q + len_ext;
            col_base_d  = band_base_q + len_ext;
            band_done_d = 1'b1;
            state_d     = R0;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        cnt_clear = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      length_q    <= '0;
      width_q     <= '0;
      band_base_q <= '0;
      col_base_q  <= '0;
      upd_q       <= 1'b0;
      band_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      length_q    <= length_d;
      width_q     <= width_d;
      band_base_q <= band_base_d;
      col_base_q  <= col_base_d;
      upd_q       <= upd_d;
      band_done_q <= band_done_d;
    end
  end

  always_comb begin
    HADDR_r    = '0;
    addr_valid = 1'b0;
    case (state_q)
      R0: begin
        HADDR_r    = col_base_q;
        addr_valid = 1'b1;
      end
      R1: begin
        HADDR_r    = col_base_q + len_ext;
        addr_valid = 1'b1;
      end
      R2: begin
        HADDR_r    = col_base_q + len2_ext;
        addr_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign addr_update_enable_r = upd_q;
  assign band_done            = band_done_q;
  assign frame_done           = (state_q == DONE);
  assign busy                 = (state_q != IDLE);

endmodule

// File: doc/read_window_addr_gen.md
Name: read_window_addr_gen

Overview:
- Read-side address sequencer for the edge-detection AHB master.
- Walks a source image in 3-row bands, column-word by column-word. For each column word it issues the three vertically stacked word addresses that a 3x3 Sobel window needs.
- Drives addr_update_enable_r into address_column_counter_r, and consumes that counter's plus4_r "last column of row" flag to decide when to step to the next band.
- Sits between the AHB master read channel (HADDR issue/accept) and the column counter.

Parameters:
- ADDR_W, 32, address width of base_addr and HADDR_r.
- DIM_W, 16, width of length, width and the internal band counter.

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a frame; ignored unless in IDLE
- base_addr  in  ADDR_W  byte address of pixel (0,0); word aligned
- length  in  DIM_W  row length in bytes; multiple of 4; same value given to address_column_counter_r
- width  in  DIM_W  number of image rows
- beat_ack  in  1  AHB master accepted the current HADDR_r this cycle
- plus4_r  in  1  from address_column_counter_r; high while the current column is the last column of the row
- addr_update_enable_r  out  1  one-cycle pulse; advances address_column_counter_r
- HADDR_r  out  ADDR_W  current read address
- addr_valid  out  1  HADDR_r is a live request
- band_done  out  1  one-cycle pulse when a band finishes and more bands remain
- frame_done  out  1  one-cycle pulse when the frame finishes
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, HRESETn=0):
  - state=IDLE.
  - HADDR_r=0, addr_valid=0, addr_update_enable_r=0, band_done=0, frame_done=0, busy=0.
  - band_base=0, col_base=0, band_cnt=0.
- States: IDLE, R0, R1, R2, DONE. All outputs are registered or decoded from registered state only. No input-to-output combinational path.
- IDLE:
  - On start: latch base_addr, length and width. Set band_base=col_base=base_addr and band_cnt=0.
  - If width<3 or length<4, go to DONE. Otherwise go to R0.
- Latency: start sampled at edge n gives addr_valid=1 and HADDR_r=base_addr from edge n+1.
- Addresses per state:
  - R0: HADDR_r=col_base.
  - R1: HADDR_r=col_base+length.
  - R2: HADDR_r=col_base+2*length.
  - addr_valid=1 in R0, R1 and R2.
- Stall: while beat_ack=0, state and HADDR_r hold unchanged for any number of cycles.
- beat_ack in R0 moves to R1. beat_ack in R1 moves to R2.
- beat_ack in R2 produces addr_update_enable_r=1 for exactly the next cycle, then:
  - plus4_r=0: col_base += 4; go to R0.
  - plus4_r=1 and band_cnt != width-3: band_cnt += 1; band_base += length; col_base = new band_base; band_done pulse; go to R0.
  - plus4_r=1 and band_cnt == width-3: go to DONE.
- plus4_r is sampled only at a beat_ack in R2. Its value at any other time is don't-care.
- DONE: frame_done=1 for one cycle, addr_valid=0, then go to IDLE. busy drops on the same edge that enters IDLE.
- Arithmetic:
  - Address sums are ADDR_W bits and wrap modulo 2^ADDR_W.
  - 2*length is zero-extended before the add.
  - band_cnt is DIM_W bits. width-3 is computed only when width>=3.
- Simultaneous events:
  - start while busy is ignored; latched operands stay stable.
  - beat_ack outside R0/R1/R2 is ignored.
- Reset asserted mid-frame returns to IDLE immediately. No frame_done pulse is produced. The column counter is reset by the same HRESETn.

Decomposition:
- Shared package (edge_pkg):
  - state typedef rd_state_t {IDLE,R0,R1,R2,DONE}.
  - constants WORD_BYTES=4 and WIN_ROWS=3.
- Sub-module: reuse flex_counter #(DIM_W) as the band counter.
  - count_enable = band-advance event.
  - rollover_val = width-2.
  - Its rollover_flag qualifies the last band.
- Next-state and address logic stays in this module.

Test Plan:
- base=0x1000, length=8, width=3; bench column-counter model raises plus4_r on the 2nd column; beat_ack always 1 -> HADDR_r sequence 1000,1008,1010,1004,100C,1014; addr_update_enable_r pulses twice; no band_done; frame_done once; then IDLE.
- Same settings but width=4 -> first band as above, band_done pulse, then 1008,1010,1018,100C,1014,101C, frame_done; 12 beats total.
- width=3 run with beat_ack held low 5 cycles in R1 -> HADDR_r holds 0x1008 and addr_valid holds 1 throughout the stall; final sequence unchanged.
- start with width=2 -> no addr_valid, frame_done 2 cycles after start; start with length=0 -> same.
- start pulsed again while in R2 -> ignored; addresses unaffected.
- HRESETn low in R1 mid-frame -> all outputs 0 asynchronously; a new start after release restarts at base_addr.
